// File: rtl/s_mem_arbiter.sv
// Request/grant arbiter with bus locking for the shared S working RAM.
// Define S_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module s_mem_arbiter #(
  parameter int N_REQ  = 3,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  input  logic [N_REQ-1:0]    op_valid,
  input  logic [N_REQ-1:0]    op_wren,
  input  logic [N_REQ*AW-1:0] op_addr,
  input  logic [N_REQ*DW-1:0] op_wdata,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_data,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      w_owner_nxt;
  logic [IW-1:0]      w_winner;
  logic [N_REQ-1:0]   r_gnt;
  logic [AW-1:0]      r_mem_addr;
  logic [DW-1:0]      r_mem_data;
  logic               r_mem_wren;
  logic [N_REQ-1:0]   r_pipe [0:RD_LAT];

  logic               w_any_req;
  logic               w_own_valid;
  logic               w_own_wren;
  logic [AW-1:0]      w_own_addr;
  logic [DW-1:0]      w_own_wdata;
  logic               w_access;
  logic               w_push;
  logic               w_pending;

  assign w_any_req   = |req;
  assign w_own_valid = op_valid[r_owner];
  assign w_own_wren  = op_wren[r_owner];
  assign w_own_addr  = op_addr[int'(r_owner)*AW +: AW];
  assign w_own_wdata = op_wdata[int'(r_owner)*DW +: DW];
  assign w_access    = (r_state == ST_OWN) && w_own_valid;
  assign w_push      = w_access && !w_own_wren;

`ifdef S_MEM_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Scan from the far end of the search order so the first requester after the pointer wins.
  always_comb begin
    int idx;
    w_winner = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) w_winner = IW'(idx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_ptr <= (w_winner == IW'(N_REQ-1)) ? '0 : w_winner + IW'(1);
    end
  end
`else
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_winner = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req[k]) w_winner = IW'(k);
    end
  end
`endif

  // Reads still in flight after this edge: this cycle's push plus every stage short of the output.
  always_comb begin
    w_pending = w_push;
    for (int k = 0; k < RD_LAT; k++) begin
      w_pending = w_pending | (|r_pipe[k]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_winner;
        end
      end
      ST_OWN: begin
        if (!req[r_owner]) w_state_nxt = w_pending ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!w_pending) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_gnt      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wren <= 1'b0;
      // NOTE: the read-tag pipeline is reset so in-flight strobes are discarded, not replayed.
      for (int k = 0; k <= RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_gnt      <= (w_state_nxt != ST_IDLE) ? (N_REQ'(1) << w_owner_nxt) : '0;
      r_mem_wren <= w_access && w_own_wren;
      if (w_access) begin
        r_mem_addr <= w_own_addr;
        r_mem_data <= w_own_wdata;
      end
      r_pipe[0] <= w_push ? (N_REQ'(1) << r_owner) : '0;
      for (int k = 1; k <= RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign gnt      = r_gnt;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_wren = r_mem_wren;
  assign rvalid   = r_pipe[RD_LAT];
  assign rdata    = mem_q;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Self-checking bench for s_mem_arbiter: a transaction-level model with due-time read queue,
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_s_mem_arbiter;

  localparam int N_REQ  = 3;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     op_valid = '0;
  logic [N_REQ-1:0]     op_wren = '0;
  logic [N_REQ*AW-1:0]  op_addr = '0;
  logic [N_REQ*DW-1:0]  op_wdata = '0;
  logic [N_REQ-1:0]     rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_data;
  logic                 mem_wren;
  logic [DW-1:0]        mem_q;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  s_mem_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
    .op_valid(op_valid), .op_wren(op_wren), .op_addr(op_addr), .op_wdata(op_wdata),
    .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: contents start as addr ^ 0x13, read data appears RD_LAT cycles after mem_addr.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] qpipe [RD_LAT];
  bit ram_ready = 0;
  assign mem_q = qpipe[RD_LAT-1];

  initial forever begin
    @(posedge clk);
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h13;
      for (int k = 0; k < RD_LAT; k++) qpipe[k] = '0;
      ram_ready = 1;
    end
    for (int k = RD_LAT-1; k > 0; k--) qpipe[k] = qpipe[k-1];
    qpipe[0] = ram[mem_addr];
    if (mem_wren) ram[mem_addr] = mem_data;
  end

  // Transaction-level model: reads are tracked by the cycle their data is due.
  typedef struct { int due; int who; logic [DW-1:0] data; } rd_t;
  rd_t pend[$];
  logic [DW-1:0] shadow [256];
  bit   shadow_ready = 0;
  int   cyc = 0, m_phase = 0, m_owner = 0, m_ptr = 0;
  logic [N_REQ-1:0] e_gnt = '0, e_rvalid = '0;
  logic [AW-1:0]    e_addr = '0;
  logic [DW-1:0]    e_data = '0, e_rdata = '0;
  logic             e_wren = 1'b0, e_busy = 1'b0;

  function automatic int pick_winner(input logic [N_REQ-1:0] r, input int ptr);
    int w;
    w = -1;
`ifdef S_MEM_ARB_RR_EN
    for (int k = 0; k < N_REQ && w < 0; k++) if (r[(ptr + k) % N_REQ]) w = (ptr + k) % N_REQ;
`else
    for (int k = 0; k < N_REQ && w < 0; k++) if (r[k]) w = k;
`endif
    return w;
  endfunction

  function automatic bit reads_after(input int c);
    bit b;
    b = 0;
    foreach (pend[i]) if (pend[i].due > c) b = 1;
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      cyc = 0; m_phase = 0; m_owner = 0; m_ptr = 0;
      pend.delete();
      e_gnt = '0; e_addr = '0; e_data = '0; e_wren = 1'b0; e_rvalid = '0; e_rdata = '0; e_busy = 1'b0;
      if (!shadow_ready) begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h13;
        shadow_ready = 1;
      end
    end else begin
      int c, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rd_t keep[$];
      rd_t ent;
      c = cyc;
      cyc++;
      e_wren = 1'b0;
      if (m_phase == 0) begin
        if (req != '0) begin
          w = pick_winner(req, m_ptr);
          m_owner = w;
          m_ptr = (w + 1) % N_REQ;
          m_phase = 1;
          e_gnt = N_REQ'(1) << w;
        end
      end else if (m_phase == 1) begin
        if (op_valid[m_owner]) begin
          a = op_addr[m_owner*AW +: AW];
          d = op_wdata[m_owner*DW +: DW];
          e_addr = a;
          e_data = d;
          e_wren = op_wren[m_owner];
          if (op_wren[m_owner]) shadow[a] = d;
          else begin
            ent.due = c + 1 + RD_LAT; ent.who = m_owner; ent.data = shadow[a];
            pend.push_back(ent);
          end
        end
        if (!req[m_owner]) begin
          if (reads_after(c)) m_phase = 2;
          else begin m_phase = 0; e_gnt = '0; end
        end
      end else begin
        if (!reads_after(c)) begin m_phase = 0; e_gnt = '0; end
      end
      e_rvalid = '0;
      foreach (pend[i]) if (pend[i].due == c + 1) begin
        e_rvalid[pend[i].who] = 1'b1;
        e_rdata = pend[i].data;
      end
      foreach (pend[i]) if (pend[i].due > c + 1) keep.push_back(pend[i]);
      pend = keep;
      e_busy = (m_phase != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cyc_gnt", 32'(gnt), 32'(e_gnt));
    check("cyc_mem_addr", 32'(mem_addr), 32'(e_addr));
    check("cyc_mem_data", 32'(mem_data), 32'(e_data));
    check("cyc_mem_wren", 32'(mem_wren), 32'(e_wren));
    check("cyc_rvalid", 32'(rvalid), 32'(e_rvalid));
    check("cyc_busy", 32'(busy), 32'(e_busy));
    if (e_rvalid != '0) check("cyc_rdata", 32'(rdata), 32'(e_rdata));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_addr[i*AW +: AW]  = a;
    op_wdata[i*DW +: DW] = d;
    op_wren[i]  = wr;
    op_valid[i] = 1'b1;
  endtask

  task automatic op(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_op(i, wr, a, d);
    tick();
    op_valid[i] = 1'b0;
  endtask

  task automatic wait_any_gnt(output int who);
    who = -1;
    for (int k = 0; k < 20 && who < 0; k++) begin
      if (gnt != '0) begin
        for (int j = 0; j < N_REQ; j++) if (gnt[j]) who = j;
      end else tick();
    end
    if (who < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout @%0t: got no grant within 20 cycles, required one", $time);
      who = 0;
    end
  endtask

  int order[4];
  int exp_order[4];
  int who;

  initial begin
`ifdef S_MEM_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    repeat (3) @(posedge clk);
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wren", 32'(mem_wren), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    tick();

    // Grant latency and write path.
    req = 3'b001;
    tick();
    check("grant0", 32'(gnt), 32'h1);
    op(0, 1'b1, 8'h10, 8'h10);
    check("wr_addr", 32'(mem_addr), 32'h10);
    check("wr_data", 32'(mem_data), 32'h10);
    check("wr_wren", 32'(mem_wren), 32'h1);

    // Non-owner access while owner 0 is quiet.
    op(2, 1'b1, 8'hFF, 8'hEE);
    check("nonowner_wren", 32'(mem_wren), 32'h0);
    check("nonowner_addr", 32'(mem_addr), 32'h10);
    check("nonowner_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    check("release0_gnt", 32'(gnt), 32'h0);
    check("release0_busy", 32'(busy), 32'h0);

    // Owner 1 read: rvalid two cycles after op_valid.
    req[1] = 1'b1;
    tick();
    check("grant1", 32'(gnt), 32'h2);
    op(1, 1'b0, 8'h49, 8'h00);
    tick();
    check("rd_rvalid", 32'(rvalid), 32'h2);
    check("rd_rdata", 32'(rdata), 32'h5A);
    op(1, 1'b1, 8'h49, 8'hC3);
    op(1, 1'b0, 8'h49, 8'h00);
    op(1, 1'b0, 8'h10, 8'h00);
    tick();
    tick();

    // Read and release in the same cycle with requester 2 waiting.
    req[2] = 1'b1;
    tick();
    set_op(1, 1'b0, 8'h20, 8'h00);
    req[1] = 1'b0;
    tick();
    op_valid[1] = 1'b0;
    check("drain_gnt", 32'(gnt), 32'h2);
    check("drain_busy", 32'(busy), 32'h1);
    tick();
    check("drain_rvalid", 32'(rvalid), 32'h2);
    check("drain_rdata", 32'(rdata), 32'h33);
    check("drain_gnt_hold", 32'(gnt), 32'h2);
    tick();
    check("handoff_dead", 32'(gnt), 32'h0);
    tick();
    check("handoff_gnt2", 32'(gnt), 32'h4);
    op(2, 1'b1, 8'h30, 8'h77);
    op(2, 1'b0, 8'h30, 8'h00);
    req[2] = 1'b0;
    repeat (4) tick();

    // All requesters contending; each releases after four accesses.
    req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      wait_any_gnt(who);
      order[s] = who;
      for (int k = 0; k < 4; k++) op(who, 1'b1, 8'(8'h40 + s*4 + k), 8'(8'hA0 + s*4 + k));
      req[who] = 1'b0;
      tick();
      req[who] = 1'b1;
    end
    req = '0;
    repeat (3) tick();
    for (int s = 0; s < 4; s++) check($sformatf("grant_order_%0d", s), 32'(order[s]), 32'(exp_order[s]));

    // Reset while draining a read.
    req[0] = 1'b1;
    wait_any_gnt(who);
    set_op(0, 1'b0, 8'h55, 8'h00);
    req[0] = 1'b0;
    tick();
    op_valid[0] = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_wren", 32'(mem_wren), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_rvalid", 32'(rvalid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
